vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing from the board system clock.
- Sits directly upstream of the pixel-colour stages, which consume bright, hcount and vcount.
- Drives hsync/vsync to the DAC/connector and provides a pixel-enable strobe and a frame-start pulse for downstream logic.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_pix_div.sv | 33 +++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the raster generator and the downstream
// pixel-colour stages. Holds the 640x480@60 defaults, derived totals, the
// sync/visible boundaries and a region decode helper.
package vga_pkg;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] count_t;

    // Default 640x480@60 timing (pixels / lines)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync windows are [start, end): hsync 656..751, vsync 490..491
    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic bright;
    } region_t;

    // Decode a raster position into active-low syncs and the visible flag.
    function automatic region_t region_decode(
        input count_t h,
        input count_t v,
        input count_t h_vis,
        input count_t hs_start,
        input count_t hs_end,
        input count_t v_vis,
        input count_t vs_start,
        input count_t vs_end
    );
        region_t r;
        r.hsync  = !((h >= hs_start) && (h < hs_end));
        r.vsync  = !((v >= vs_start) && (v < vs_end));
        r.bright = (h < h_vis) && (v < v_vis);
        return r;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Clock-enable divider: produces a one-clk pix_en strobe every CLK_DIV
// system clocks. The strobe is registered, so the first one appears CLK_DIV
// clocks after reset release; with CLK_DIV=1 it stays high after reset.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div;

    // Free-running 0..CLK_DIV-1 count; strobe registered from the terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div == DIV_LAST);
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DIV_ONE;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default).
// Counters advance on pix_en; hsync/vsync/bright are registered from the
// next-state counters so they stay cycle-aligned with hcount/vcount.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             bright,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam count_t H_LAST   = count_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam count_t V_LAST   = count_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam count_t H_VIS    = count_t'(H_VISIBLE);
    localparam count_t HS_START = count_t'(H_VISIBLE + H_FP);
    localparam count_t HS_END   = count_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam count_t V_VIS    = count_t'(V_VISIBLE);
    localparam count_t VS_START = count_t'(V_VISIBLE + V_FP);
    localparam count_t VS_END   = count_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam count_t CNT_ONE  = count_t'(1);

    count_t  h_next;
    count_t  v_next;
    logic    wrap;
    region_t region_next;

    vga_pix_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_div (
        .clk   (clk),
        .reset (reset),
        .pix_en(pix_en)
    );

    // Next raster position and full-frame wrap detect for this clk
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        wrap   = 1'b0;
        if (pix_en) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                if (vcount == V_LAST) begin
                    v_next = '0;
                    wrap   = 1'b1;
                end else begin
                    v_next = vcount + CNT_ONE;
                end
            end else begin
                h_next = hcount + CNT_ONE;
            end
        end
    end

    assign region_next = region_decode(h_next, v_next, H_VIS, HS_START, HS_END,
                                       V_VIS, VS_START, VS_END);

    // Raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
        end
    end

    // Sync/visible flags decoded from next-state counters; frame_start only on wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= region_next.hsync;
            vsync       <= region_next.vsync;
            bright      <= region_next.bright;
            frame_start <= wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start; wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (wrap) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default timing at CLK_DIV=2,
// default timing at CLK_DIV=1, and a shrunken raster at CLK_DIV=2 so whole
// frames fit in a short run) compared every clk against a closed-form model
// derived from elapsed clocks since reset release, plus literal spot checks.
// Honours VGA_FRAME_CNT_EN for the frame_count port.
module tb_vga_timing_gen;

    // Shrunken raster for instance c: 58 x 19, frame = 1102 pixels = 2204 clks
    localparam int C_HV = 40, C_HF = 4, C_HS = 8, C_HB = 6;
    localparam int C_VV = 12, C_VF = 2, C_VS = 2, C_VB = 3;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       pe_a, hs_a, vs_a, br_a, fs_a;
    logic [9:0] hc_a, vc_a;
    logic       pe_b, hs_b, vs_b, br_b, fs_b;
    logic [9:0] hc_b, vc_b;
    logic       pe_c, hs_c, vs_c, br_c, fs_c;
    logic [9:0] hc_c, vc_c;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b, fc_c;
`endif

    int     vectors     = 0;
    int     miscompares = 0;
    int     fail_lines  = 0;
    longint t_a = 0, t_b = 0, t_c = 0;
    bit     armed = 1'b0;

    typedef struct {
        int pe; int hc; int vc; int hs; int vs; int br; int fs; int fc;
    } exp_t;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(rst_a), .pix_en(pe_a), .hcount(hc_a), .vcount(vc_a),
        .hsync(hs_a), .vsync(vs_a), .bright(br_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_a)
`endif
    );

    vga_timing_gen #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(pe_b), .hcount(hc_b), .vcount(vc_b),
        .hsync(hs_b), .vsync(vs_b), .bright(br_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_b)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(2),
        .H_VISIBLE(C_HV), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
        .V_VISIBLE(C_VV), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB)
    ) dut_c (
        .clk(clk), .reset(rst_c), .pix_en(pe_c), .hcount(hc_c), .vcount(vc_c),
        .hsync(hs_c), .vsync(vs_c), .bright(br_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_c)
`endif
    );

    // Expected outputs after t clk edges since reset release (t=0: in reset).
    // Pixel advances happen on edges that follow a pix_en clk, so after edge t
    // the raster has moved n = (t-1)/d pixels from (0,0).
    function automatic exp_t model(input longint t, input int d,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb);
        exp_t   e;
        longint n;
        int     ht, vt;
        longint ft;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        ft = longint'(ht) * longint'(vt);
        if (t == 0) begin
            e.pe = 0; e.hc = 0; e.vc = 0; e.hs = 1; e.vs = 1;
            e.br = 0; e.fs = 0; e.fc = 0;
            return e;
        end
        n    = (t - 1) / d;
        e.pe = ((t % d) == 0) ? 1 : 0;
        e.hc = int'(n % ht);
        e.vc = int'((n / ht) % vt);
        e.hs = (e.hc >= hv + hf && e.hc < hv + hf + hs) ? 0 : 1;
        e.vs = (e.vc >= vv + vf && e.vc < vv + vf + vs) ? 0 : 1;
        e.br = (e.hc < hv && e.vc < vv) ? 1 : 0;
        e.fs = (t >= 2 && ((t - 1) % d) == 0 && n > 0 && (n % ft) == 0) ? 1 : 0;
        e.fc = int'((n / ft) % 65536);
        return e;
    endfunction

    task automatic cmp(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            if (fail_lines < 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
            fail_lines++;
        end
    endtask

    task automatic check_inst(input string tag, input exp_t e,
                              input logic pe, input logic [9:0] hc, input logic [9:0] vc,
                              input logic hs, input logic vs, input logic br, input logic fs);
        cmp({tag, ".pix_en"},      int'(pe), e.pe);
        cmp({tag, ".hcount"},      int'(hc), e.hc);
        cmp({tag, ".vcount"},      int'(vc), e.vc);
        cmp({tag, ".hsync"},       int'(hs), e.hs);
        cmp({tag, ".vsync"},       int'(vs), e.vs);
        cmp({tag, ".bright"},      int'(br), e.br);
        cmp({tag, ".frame_start"}, int'(fs), e.fs);
    endtask

    // Elapsed clocks since reset release, per instance
    always @(posedge clk) begin
        t_a   <= rst_a ? 64'd0 : t_a + 64'd1;
        t_b   <= rst_b ? 64'd0 : t_b + 64'd1;
        t_c   <= rst_c ? 64'd0 : t_c + 64'd1;
        armed <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        exp_t ea, eb, ec;
        if (armed) begin
            ea = model(t_a, 2, 640, 16, 96, 48, 480, 10, 2, 33);
            eb = model(t_b, 1, 640, 16, 96, 48, 480, 10, 2, 33);
            ec = model(t_c, 2, C_HV, C_HF, C_HS, C_HB, C_VV, C_VF, C_VS, C_VB);
            check_inst("a", ea, pe_a, hc_a, vc_a, hs_a, vs_a, br_a, fs_a);
            check_inst("b", eb, pe_b, hc_b, vc_b, hs_b, vs_b, br_b, fs_b);
            check_inst("c", ec, pe_c, hc_c, vc_c, hs_c, vs_c, br_c, fs_c);
`ifdef VGA_FRAME_CNT_EN
            cmp("a.frame_count", int'(fc_a), ea.fc);
            cmp("b.frame_count", int'(fc_b), eb.fc);
            cmp("c.frame_count", int'(fc_c), ec.fc);
`endif
        end
    end

    task automatic seq_a();
        int guard;
        int hs_low;
        int br_hi;
        rst_a = 1'b0;
        repeat ($urandom_range(1, 7)) @(negedge clk);
        rst_a = 1'b1;
        repeat (5) @(negedge clk);
        cmp("a.rst_hcount", int'(hc_a), 0);
        cmp("a.rst_vcount", int'(vc_a), 0);
        cmp("a.rst_hsync", int'(hs_a), 1);
        cmp("a.rst_vsync", int'(vs_a), 1);
        cmp("a.rst_bright", int'(br_a), 0);
        cmp("a.rst_frame_start", int'(fs_a), 0);
        cmp("a.rst_pix_en", int'(pe_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        cmp("a.bright_clk1", int'(br_a), 1);
        cmp("a.pix_en_clk1", int'(pe_a), 0);
        @(negedge clk);
        cmp("a.pix_en_clk2", int'(pe_a), 1);
        guard = 0;
        while (!(hc_a == 10'd799 && vc_a == 10'd10 && pe_a) && guard < 25000) begin
            @(negedge clk);
            guard++;
        end
        cmp("a.reach_799_10_in_budget", (guard < 25000) ? 1 : 0, 1);
        @(negedge clk);
        cmp("a.wrap_hcount", int'(hc_a), 0);
        cmp("a.wrap_vcount", int'(vc_a), 11);
        hs_low = 0;
        br_hi  = 0;
        for (int i = 0; i < 1600; i++) begin
            if (!hs_a) hs_low++;
            if (br_a) br_hi++;
            @(negedge clk);
        end
        cmp("a.line11_hsync_low_clks", hs_low, 192);
        cmp("a.line11_bright_clks", br_hi, 1280);
        cmp("a.line12_hcount", int'(hc_a), 0);
        cmp("a.line12_vcount", int'(vc_a), 12);
    endtask

    task automatic seq_b();
        int guard;
        int cnt;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        rst_b = 1'b0;
        guard = 0;
        while (!(hc_b == 10'd1 && vc_b == 10'd0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        cmp("b.reach_first_pixel", (guard < 2000) ? 1 : 0, 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(hc_b == 10'd1 && vc_b == 10'd1) && cnt < 2000);
        cmp("b.line_period_clks", cnt, 800);
        cmp("b.pix_en_steady", int'(pe_b), 1);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 3000)) @(negedge clk);
            rst_b = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_b = 1'b0;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic seq_c();
        int guard;
        int cnt;
        int vs_low;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        rst_c = 1'b0;
        guard = 0;
        while (!fs_c && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        cmp("c.first_frame_start", (guard < 5000) ? 1 : 0, 1);
`ifdef VGA_FRAME_CNT_EN
        cmp("c.frame_count_first", int'(fc_c), 1);
`endif
        cnt    = 0;
        vs_low = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!vs_c) vs_low++;
        end while (!fs_c && cnt < 5000);
        cmp("c.frame_period_clks", cnt, 2204);
        cmp("c.vsync_low_clks", vs_low, 232);
        guard = 0;
        while (!(vc_c == 10'd15 && hc_c == 10'd20 && !vs_c) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        cmp("c.reach_mid_vsync", (guard < 5000) ? 1 : 0, 1);
        rst_c = 1'b1;
        @(negedge clk);
        cmp("c.midrst_hcount", int'(hc_c), 0);
        cmp("c.midrst_vcount", int'(vc_c), 0);
        cmp("c.midrst_hsync", int'(hs_c), 1);
        cmp("c.midrst_vsync", int'(vs_c), 1);
        cmp("c.midrst_bright", int'(br_c), 0);
        cmp("c.midrst_frame_start", int'(fs_c), 0);
        cmp("c.midrst_pix_en", int'(pe_c), 0);
`ifdef VGA_FRAME_CNT_EN
        cmp("c.midrst_frame_count", int'(fc_c), 0);
`endif
        rst_c = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 3000)) @(negedge clk);
            rst_c = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_c = 1'b0;
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        fork
            seq_a();
            seq_b();
            seq_c();
        join
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
